// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and default geometry for the HUB75 receiver
//
// Purpose : common localparams and typedefs used by hub75_rx and its sub-module.
// Contents: default panel geometry, ADDR_W / PLANE_W widths, rgb_t / row_t types,
//           collect-FSM state encoding.
package hub75_pkg;

    localparam int NUM_COLS_DEF  = 64;
    localparam int SCAN_RATE_DEF = 32;
    localparam int RGB_RES_DEF   = 9;

    localparam int ADDR_W  = $clog2(SCAN_RATE_DEF);
    localparam int PLANE_W = $clog2(RGB_RES_DEF);

    typedef logic [2:0] rgb_t;
    typedef rgb_t [NUM_COLS_DEF-1:0] row_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } col_state_e;

endpackage

// File: rtl/hub75_edge_detect.sv
// rtl/hub75_edge_detect.sv - registered rising-edge detector for one panel pin
//
// Purpose : holds the previous-cycle value of a synchronous pin and flags 0->1.
// Ports   : clk_in  - system clock
//           rst_in  - asynchronous active-low reset
//           sig_i   - pin value (already synchronous to clk_in)
//           rise_o  - one-cycle pulse when sig_i=1 and previous value was 0
module hub75_edge_detect (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/hub75_rx.sv
// rtl/hub75_rx.sv - HUB75 panel-side receiver: deserializes latched rows onto a valid/ready stream
//
// Purpose : samples the panel pins, rebuilds each latched row (upper/lower halves),
//           tags it with scan address and bit-plane index, and holds it in a
//           one-entry output buffer.
// Ports   : clk_in, rst_in (async active-low)
//           hub75_clk, hub75_rgb0, hub75_rgb1, hub75_latch, hub75_OE, hub75_addr - panel pins
//           m_rgb0, m_rgb1, m_addr, m_plane, m_valid, m_ready, m_last       - row stream
//           err_short, err_long, err_overrun (sticky), clr_err              - error status
//           m_oe_cycles (only with HUB75_RX_OE_MEAS_EN) - OE-low cycles of the previous row
// Options : HUB75_RX_OE_MEAS_EN adds the output-enable on-time counter.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int NUM_COLS  = NUM_COLS_DEF,
    parameter int SCAN_RATE = SCAN_RATE_DEF,
    parameter int RGB_RES   = RGB_RES_DEF
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          hub75_clk,
    input  logic [2:0]                    hub75_rgb0,
    input  logic [2:0]                    hub75_rgb1,
    input  logic                          hub75_latch,
    input  logic                          hub75_OE,
    input  logic [$clog2(SCAN_RATE)-1:0]  hub75_addr,
    output logic [NUM_COLS*3-1:0]         m_rgb0,
    output logic [NUM_COLS*3-1:0]         m_rgb1,
    output logic [$clog2(SCAN_RATE)-1:0]  m_addr,
    output logic [$clog2(RGB_RES)-1:0]    m_plane,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
`ifdef HUB75_RX_OE_MEAS_EN
    output logic [15:0]                   m_oe_cycles,
`endif
    output logic                          err_short,
    output logic                          err_long,
    output logic                          err_overrun,
    input  logic                          clr_err
);

    localparam int AW  = $clog2(SCAN_RATE);
    localparam int PW  = $clog2(RGB_RES);
    localparam int CW  = $clog2(NUM_COLS + 1);
    localparam int CIW = $clog2(NUM_COLS);

    typedef rgb_t [NUM_COLS-1:0] line_t;

    logic shift_p;
    logic commit_p;

    hub75_edge_detect u_clk_edge (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .sig_i  (hub75_clk),
        .rise_o (shift_p)
    );

    hub75_edge_detect u_latch_edge (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .sig_i  (hub75_latch),
        .rise_o (commit_p)
    );

    col_state_e    state_q, state_d;
    logic [CW-1:0] pix_q, pix_d;
    line_t         sh0_q, sh0_d, sh1_q, sh1_d;
    logic [AW-1:0] prev_addr_q, prev_addr_d;
    logic [PW-1:0] plane_q, plane_d;
    logic          seen_q, seen_d;

    line_t         buf0_q, buf0_d, buf1_q, buf1_d;
    logic [AW-1:0] baddr_q, baddr_d;
    logic [PW-1:0] bplane_q, bplane_d;
    logic          bvalid_q, bvalid_d;
    logic          blast_q, blast_d;

    logic          err_short_q, err_short_d;
    logic          err_long_q, err_long_d;
    logic          err_over_q, err_over_d;

    logic          set_short, set_long, set_over;
    logic          load;
    logic [CIW-1:0] col_idx;
    line_t         row0, row1;

    assign col_idx = pix_q[CIW-1:0];

    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        prev_addr_d = prev_addr_q;
        plane_d     = plane_q;
        seen_d      = seen_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        baddr_d     = baddr_q;
        bplane_d    = bplane_q;
        bvalid_d    = bvalid_q;
        blast_d     = blast_q;
        set_short   = 1'b0;
        set_long    = 1'b0;
        set_over    = 1'b0;
        load        = 1'b0;
        row0        = '0;
        row1        = '0;

        // Shift is applied before a coincident commit so the last column is kept.
        if (shift_p) begin
            case (state_q)
                ST_IDLE, ST_SHIFT: begin
                    sh0_d[col_idx] = hub75_rgb0;
                    sh1_d[col_idx] = hub75_rgb1;
                    pix_d          = pix_q + 1'b1;
                    state_d        = (pix_q == CW'(NUM_COLS - 1)) ? ST_FULL : ST_SHIFT;
                end
                ST_FULL: set_long = 1'b1;
                default: state_d = ST_IDLE;
            endcase
        end

        if (bvalid_q && m_ready) begin
            bvalid_d = 1'b0;
        end

        if (commit_p) begin
            row0      = sh0_d;
            row1      = sh1_d;
            set_short = (pix_d < CW'(NUM_COLS));
            pix_d     = '0;
            state_d   = ST_IDLE;
            // Cleared so a following short row reads zeros in unshifted columns.
            sh0_d     = '0;
            sh1_d     = '0;

            // Repeated address means the next bit plane of the same row.
            if (seen_q && (hub75_addr == prev_addr_q)) begin
                plane_d = (plane_q == PW'(RGB_RES - 1)) ? '0 : plane_q + 1'b1;
            end else begin
                plane_d = '0;
            end
            prev_addr_d = hub75_addr;
            seen_d      = 1'b1;

            if (!bvalid_q || m_ready) begin
                load     = 1'b1;
                buf0_d   = row0;
                buf1_d   = row1;
                baddr_d  = hub75_addr;
                bplane_d = plane_d;
                bvalid_d = 1'b1;
                blast_d  = (hub75_addr == AW'(SCAN_RATE - 1)) && (plane_d == PW'(RGB_RES - 1));
            end else begin
                set_over = 1'b1;
            end
        end

        err_short_d = set_short | (err_short_q & ~clr_err);
        err_long_d  = set_long  | (err_long_q  & ~clr_err);
        err_over_d  = set_over  | (err_over_q  & ~clr_err);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            pix_q       <= '0;
            sh0_q       <= '0;
            sh1_q       <= '0;
            prev_addr_q <= '0;
            plane_q     <= '0;
            seen_q      <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            baddr_q     <= '0;
            bplane_q    <= '0;
            bvalid_q    <= 1'b0;
            blast_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            prev_addr_q <= prev_addr_d;
            plane_q     <= plane_d;
            seen_q      <= seen_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            baddr_q     <= baddr_d;
            bplane_q    <= bplane_d;
            bvalid_q    <= bvalid_d;
            blast_q     <= blast_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_over_q  <= err_over_d;
        end
    end

`ifdef HUB75_RX_OE_MEAS_EN
    logic [15:0] oe_cnt_q, oe_cnt_d;
    logic [15:0] boe_q, boe_d;

    // The count seen at a commit is the on-time of the row displayed before it.
    always_comb begin
        oe_cnt_d = oe_cnt_q;
        boe_d    = boe_q;
        if (commit_p) begin
            oe_cnt_d = '0;
        end else if (!hub75_OE && (oe_cnt_q != 16'hFFFF)) begin
            oe_cnt_d = oe_cnt_q + 16'd1;
        end
        if (load) begin
            boe_d = oe_cnt_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            oe_cnt_q <= '0;
            boe_q    <= '0;
        end else begin
            oe_cnt_q <= oe_cnt_d;
            boe_q    <= boe_d;
        end
    end

    assign m_oe_cycles = boe_q;
`else
    logic unused_oe;
    assign unused_oe = hub75_OE ^ load;
`endif

    assign m_rgb0      = buf0_q;
    assign m_rgb1      = buf1_q;
    assign m_addr      = baddr_q;
    assign m_plane     = bplane_q;
    assign m_valid     = bvalid_q;
    assign m_last      = bvalid_q & blast_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign err_overrun = err_over_q;

endmodule

// File: tb/tb_hub75_rx.sv
// tb/tb_hub75_rx.sv - self-checking bench for hub75_rx with a row-level reference model
module tb_hub75_rx;

    localparam int NC = 64;
    localparam int SR = 32;
    localparam int RR = 9;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic             hub75_clk = 1'b0;
    logic [2:0]       hub75_rgb0 = '0;
    logic [2:0]       hub75_rgb1 = '0;
    logic             hub75_latch = 1'b0;
    logic             hub75_OE = 1'b1;
    logic [4:0]       hub75_addr = '0;
    logic [NC*3-1:0]  m_rgb0, m_rgb1;
    logic [4:0]       m_addr;
    logic [3:0]       m_plane;
    logic             m_valid, m_last;
    logic             m_ready = 1'b0;
    logic             err_short, err_long, err_overrun;
    logic             clr_err = 1'b0;
`ifdef HUB75_RX_OE_MEAS_EN
    logic [15:0]      m_oe_cycles;
`endif

    hub75_rx #(.NUM_COLS(NC), .SCAN_RATE(SR), .RGB_RES(RR)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .hub75_clk   (hub75_clk),
        .hub75_rgb0  (hub75_rgb0),
        .hub75_rgb1  (hub75_rgb1),
        .hub75_latch (hub75_latch),
        .hub75_OE    (hub75_OE),
        .hub75_addr  (hub75_addr),
        .m_rgb0      (m_rgb0),
        .m_rgb1      (m_rgb1),
        .m_addr      (m_addr),
        .m_plane     (m_plane),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
`ifdef HUB75_RX_OE_MEAS_EN
        .m_oe_cycles (m_oe_cycles),
`endif
        .err_short   (err_short),
        .err_long    (err_long),
        .err_overrun (err_overrun),
        .clr_err     (clr_err)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    // Reference model state: one held row, sticky flags, run length of same-address commits.
    logic [NC*3-1:0] cur0, cur1, hold0, hold1;
    int  hold_addr, hold_plane;
    bit  hold_last, buf_v;
    bit  exp_short, exp_long, exp_over;
    bit  seen;
    int  prev_addr, run_len;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        buf_v = 0; exp_short = 0; exp_long = 0; exp_over = 0;
        seen = 0; prev_addr = 0; run_len = 0;
        hold0 = '0; hold1 = '0; hold_addr = 0; hold_plane = 0; hold_last = 0;
    endtask

    task automatic do_shift(input logic [2:0] r0, input logic [2:0] r1);
        @(negedge clk_in);
        hub75_rgb0 = r0; hub75_rgb1 = r1; hub75_clk = 1'b1;
        @(negedge clk_in);
        hub75_clk = 1'b0;
    endtask

    // n shifts then a latch at address a; pat selects the col / ~col pattern.
    task automatic send_row(input int n, input int a, input bit pat, input bit rdy);
        logic [2:0] r0, r1;
        int plane;
        cur0 = '0; cur1 = '0;
        for (int c = 0; c < n; c++) begin
            if (pat) begin
                r0 = c[2:0]; r1 = ~c[2:0];
            end else begin
                r0 = 3'($urandom); r1 = 3'($urandom);
            end
            do_shift(r0, r1);
            if (c < NC) begin
                cur0[3*c +: 3] = r0; cur1[3*c +: 3] = r1;
            end else begin
                exp_long = 1;
            end
        end
        @(negedge clk_in);
        hub75_addr = 5'(a); hub75_latch = 1'b1;
        if (rdy) m_ready = 1'b1;
        @(negedge clk_in);
        hub75_latch = 1'b0; m_ready = 1'b0;
        if (n < NC) exp_short = 1;
        if (seen && a == prev_addr) run_len++; else run_len = 0;
        plane = run_len % RR;
        seen = 1; prev_addr = a;
        if (!buf_v || rdy) begin
            hold0 = cur0; hold1 = cur1; hold_addr = a; hold_plane = plane;
            hold_last = (a == SR - 1) && (plane == RR - 1);
            buf_v = 1;
        end else begin
            exp_over = 1;
        end
    endtask

    task automatic check_out(input string tag);
        check_val({tag, "_valid"}, m_valid, buf_v);
        if (buf_v) begin
            check_val({tag, "_addr"}, m_addr, hold_addr);
            check_val({tag, "_plane"}, m_plane, hold_plane);
            check_val({tag, "_last"}, m_last, hold_last);
            check_val({tag, "_rgb0"}, m_rgb0, hold0);
            check_val({tag, "_rgb1"}, m_rgb1, hold1);
        end
    endtask

    task automatic check_err(input string tag);
        check_val({tag, "_short"}, err_short, exp_short);
        check_val({tag, "_long"}, err_long, exp_long);
        check_val({tag, "_over"}, err_overrun, exp_over);
    endtask

    task automatic pop();
        @(negedge clk_in);
        m_ready = 1'b1;
        @(negedge clk_in);
        m_ready = 1'b0;
        buf_v = 0;
        check_val("pop_valid", m_valid, 1'b0);
    endtask

    task automatic clear_err();
        @(negedge clk_in);
        clr_err = 1'b1;
        @(negedge clk_in);
        clr_err = 1'b0;
        exp_short = 0; exp_long = 0; exp_over = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk_in);
        check_val("rst_valid", m_valid, 1'b0);
        check_val("rst_rgb0", m_rgb0, '0);
        check_err("rst");
        rst_in = 1'b1;
        @(negedge clk_in);

        // Pattern row at address 5.
        send_row(NC, 5, 1, 0);
        check_out("pat");
        check_err("pat");
        pop();

        // Ten rows at address 31: planes 0..8 then wrap.
        for (int i = 0; i < 10; i++) begin
            send_row(NC, 31, 0, 0);
            check_out($sformatf("plane%0d", i));
            pop();
        end

        // Short row, clear, then long row.
        send_row(40, 12, 0, 0);
        check_out("short");
        check_err("short");
        pop();
        clear_err();
        check_err("clr");
        send_row(70, 13, 0, 0);
        check_out("long");
        check_err("long");
        pop();
        clear_err();

        // Overrun, then reload in the same cycle as a handshake.
        send_row(NC, 3, 0, 0);
        send_row(NC, 4, 0, 0);
        check_out("ovr");
        check_err("ovr");
        clear_err();
        send_row(NC, 6, 0, 1);
        check_out("reload");
        check_err("reload");
        pop();

        // Reset mid-row with a held row and a sticky error present.
        send_row(10, 7, 0, 0);
        check_err("prerst");
        for (int c = 0; c < 20; c++) do_shift(3'($urandom), 3'($urandom));
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check_val("mrst_valid", m_valid, 1'b0);
        check_val("mrst_short", err_short, 1'b0);
        check_val("mrst_rgb0", m_rgb0, '0);
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
        send_row(NC, 7, 0, 0);
        check_out("postrst");
        check_err("postrst");
        pop();

        // Random rows over a small address set to exercise plane runs and length errors.
        for (int i = 0; i < 20; i++) begin
            int a, n;
            a = $urandom_range(0, 2);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 68) : NC;
            clear_err();
            send_row(n, a, 0, 0);
            check_out($sformatf("rnd%0d", i));
            check_err($sformatf("rnd%0d", i));
            pop();
        end

`ifdef HUB75_RX_OE_MEAS_EN
        send_row(NC, 9, 0, 0);
        pop();
        @(negedge clk_in);
        hub75_OE = 1'b0;
        repeat (100) @(negedge clk_in);
        hub75_OE = 1'b1;
        send_row(NC, 10, 0, 0);
        check_val("oe_cycles", m_oe_cycles, 16'd100);
        pop();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
